// File: rtl/ex_mdu_if.sv
// Execute-stage <-> multiply/divide unit handshake and result bus.
interface ex_mdu_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic              annul_i;
  logic              stallreq_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, op_a_i, op_b_i, annul_i,
    input  stallreq_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, op_a_i, op_b_i, annul_i,
    output stallreq_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: single-cycle multiply, restoring
// radix-2 divide (one quotient bit per cycle), HI/LO result registers.
module ex_mdu #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic    clk,
  input logic    rst,
  ex_mdu_if.slave mdu
);
  localparam int MSB = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem, quo, dvs;
  logic                q_neg, r_neg;
  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   stg_hi, stg_lo;

  logic                go, is_div, is_uns, b_zero, last_step;
  logic [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W:0]     trial;
  logic                borrow;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt, q_fin, r_fin;

  assign go        = (state == IDLE) && mdu.start_i && !mdu.annul_i;
  assign is_div    = mdu.op_i[1];
  assign is_uns    = mdu.op_i[0];
  assign b_zero    = (mdu.op_b_i == '0);
  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  // Sign-extend (or zero-extend) to full width so one multiplier covers both ops.
  assign a_ext = {{DATA_W{!is_uns && mdu.op_a_i[MSB]}}, mdu.op_a_i};
  assign b_ext = {{DATA_W{!is_uns && mdu.op_b_i[MSB]}}, mdu.op_b_i};
  assign prod  = a_ext * b_ext;

  assign a_abs = (!is_uns && mdu.op_a_i[MSB]) ? -mdu.op_a_i : mdu.op_a_i;
  assign b_abs = (!is_uns && mdu.op_b_i[MSB]) ? -mdu.op_b_i : mdu.op_b_i;

  // Restoring step: borrow out of the trial subtraction means the bit is 0.
  assign trial   = {rem, quo[MSB]} - {1'b0, dvs};
  assign borrow  = trial[DATA_W];
  assign rem_nxt = borrow ? {rem[DATA_W-2:0], quo[MSB]} : trial[DATA_W-1:0];
  assign quo_nxt = {quo[DATA_W-2:0], !borrow};
  assign q_fin   = q_neg ? -quo_nxt : quo_nxt;
  assign r_fin   = r_neg ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the staged result that HI/LO pick up on entry to DONE.
  always_comb begin
    state_nxt = state;
    stg_hi    = hi;
    stg_lo    = lo;
    case (state)
      IDLE: begin
        if (go) begin
          if (!is_div) begin
            stg_hi    = prod[2*DATA_W-1:DATA_W];
            stg_lo    = prod[DATA_W-1:0];
            state_nxt = DONE;
          end else if (b_zero) begin
            stg_hi    = mdu.op_a_i;
            stg_lo    = '1;
            state_nxt = DONE;
          end else begin
            state_nxt = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (last_step) begin
          stg_hi    = r_fin;
          stg_lo    = q_fin;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (mdu.annul_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (go && is_div && !b_zero) begin
        quo   <= a_abs;
        dvs   <= b_abs;
        rem   <= '0;
        cnt   <= '0;
        q_neg <= !is_uns && (mdu.op_a_i[MSB] ^ mdu.op_b_i[MSB]);
        r_neg <= !is_uns && mdu.op_a_i[MSB];
      end else if (state == DIV_RUN) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 1'b1;
      end
      if (state_nxt == DONE) begin
        hi <= stg_hi;
        lo <= stg_lo;
      end
    end
  end

  assign mdu.stallreq_o = go || (state == DIV_RUN);
  assign mdu.busy_o     = (state != IDLE);
  assign mdu.done_o     = (state == DONE);
  assign mdu.hi_o       = hi;
  assign mdu.lo_o       = lo;
endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: a cycle-level result/timing model checked every
// cycle, plus literal expectations for the hand-worked vectors.
module tb_ex_mdu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mdu_if #(.DATA_W(32)) bus ();
  ex_mdu #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .mdu(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the in-flight operation and the visible HI/LO.
  bit          chk_en = 1'b0;
  bit          pend   = 1'b0;
  int          p_start, p_done;
  int          p_kill  = 1 << 30;
  int          clr_cyc = -1;
  logic [31:0] p_hi, p_lo;
  logic [31:0] m_hi = '0, m_lo = '0;
  int          stall_cnt = 0;
  bit          live, e_done, e_stall, e_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    int              sa, sb;
    longint          ps;
    longint unsigned pu;
    sa = a; sb = b;
    lat = 1;
    case (op)
      2'b00: begin ps = longint'(sa) * longint'(sb); hi = ps[63:32]; lo = ps[31:0]; end
      2'b01: begin pu = {32'h0, a} * {32'h0, b};     hi = pu[63:32]; lo = pu[31:0]; end
      default: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else begin
          lat = 33;
          if (op == 2'b11) begin
            lo = a / b; hi = a % b;
          end else if (a == 32'h8000_0000 && sb == -1) begin
            lo = a; hi = 0;
          end else begin
            lo = sa / sb; hi = sa % sb;
          end
        end
      end
    endcase
  endfunction

  task automatic model_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    model(op, a, b, p_hi, p_lo, lat);
    pend    = 1'b1;
    p_start = cyc;
    p_done  = cyc + lat;
    p_kill  = 1 << 30;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == clr_cyc) begin m_hi = '0; m_lo = '0; end
      live    = pend && (cyc <= p_kill);
      e_done  = live && (cyc == p_done);
      e_stall = live && (cyc < p_done);
      e_busy  = live && (cyc > p_start) && (cyc <= p_done);
      if (e_done) begin m_hi = p_hi; m_lo = p_lo; pend = 1'b0; end
      if (bus.stallreq_o) stall_cnt++;
      chk("done_o",     32'(bus.done_o),     32'(e_done));
      chk("stallreq_o", 32'(bus.stallreq_o), 32'(e_stall));
      chk("busy_o",     32'(bus.busy_o),     32'(e_busy));
      chk("hi_o",       bus.hi_o,            m_hi);
      chk("lo_o",       bus.lo_o,            m_lo);
      if (pend && cyc >= p_kill) pend = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = op; bus.op_a_i = a; bus.op_b_i = b;
    model_start(op, a, b);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int lat);
    int s;
    s   = p_start;
    lat = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.done_o) begin lat = cyc - s; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done timeout: got none within %0d cycles expected done_o", maxc);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] xhi, input logic [31:0] xlo,
                        input int xlat);
    int lat;
    stall_cnt = 0;
    issue(op, a, b);
    wait_done(45, lat);
    chk({nm, " latency"}, lat, xlat);
    chk({nm, " stall cycles"}, stall_cnt, xlat);
    chk({nm, " hi"}, bus.hi_o, xhi);
    chk({nm, " lo"}, bus.lo_o, xlo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected bench end");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.op_a_i = '0; bus.op_b_i = '0; bus.annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset hi", bus.hi_o, 32'h0);
    chk("reset busy", 32'(bus.busy_o), 32'h0);

    run_op("MULT -2*3",   2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
    run_op("MULTU max^2", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    run_op("DIV -7/2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("DIV 7/-2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("DIVU max/16", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33);
    run_op("DIV 0/5",     2'b10, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 33);
    run_op("DIVU 100/0",  2'b11, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, 1);
    run_op("DIV min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);

    // Annul a divide at cycle 10 of its run.
    issue(2'b11, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    p_kill = cyc;
    @(posedge clk); #1 bus.annul_i = 1'b0;
    @(negedge clk);
    chk("annul busy", 32'(bus.busy_o), 32'h0);
    chk("annul lo kept", bus.lo_o, 32'h8000_0000);
    run_op("MULTU after annul", 2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1);

    // Reset in the middle of a divide.
    issue(2'b10, 32'h7FFF_0000, 32'h0000_0003);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    p_kill = cyc; clr_cyc = cyc + 1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst hi", bus.hi_o, 32'h0);
    chk("rst lo", bus.lo_o, 32'h0);
    chk("rst busy", 32'(bus.busy_o), 32'h0);
    chk("rst stall", 32'(bus.stallreq_o), 32'h0);

    // start_i held through DONE must not launch a second operation.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.op_a_i = 32'd5; bus.op_b_i = 32'hFFFF_FFFD;
    model_start(2'b00, 32'd5, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    @(negedge clk);
    chk("held done", 32'(bus.done_o), 32'h1);
    chk("held lo", bus.lo_o, 32'hFFFF_FFF1);
    chk("held hi", bus.hi_o, 32'hFFFF_FFFF);
    @(posedge clk); #1 bus.start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held no relaunch busy", 32'(bus.busy_o), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
